// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   arb_state_e      : arbiter FSM state (WB_PRI = writeback priority,
//                      FORCE_MC = multi-cycle unit forced through)
//   REG_ADDR_W       : register-file address width
//   DATA_W_DEFAULT   : default write-data width
//   STARVE_CNT_W     : width of the multi-cycle starvation counter
package regfile_arb_pkg;

  typedef enum logic {
    WB_PRI   = 1'b0,
    FORCE_MC = 1'b1
  } arb_state_e;

  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned STARVE_CNT_W   = 4;

endpackage

// File: rtl/regfile_write_arbiter_starve_counter.sv
// starve_counter: counts consecutive cycles the multi-cycle requester is
// stalled, saturating at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : requester stalled this cycle
//   clr_i      : requester transferred or withdrew this cycle
//   hit_o      : the increment at the coming posedge reaches LIMIT
module starve_counter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned CNT_W = STARVE_CNT_W,
  parameter int unsigned LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam logic [CNT_W:0] LIM = (CNT_W + 1)'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  // inc_i and clr_i are mutually exclusive in the parent; clr_i still
  // masks the hit so a clear can never trigger a forced state.
  assign hit_o = inc_i && !clr_i && (cnt_inc >= LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates the single register-file write port
// between the pipeline writeback (priority) and a multi-cycle unit, which
// is forced through after STARVE_LIMIT consecutive stalled cycles.
//   wb_valid/wb_ready/wb_reg/wb_data : writeback request handshake
//   mc_valid/mc_ready/mc_reg/mc_data : multi-cycle request handshake
//   regWrite/writeReg/writeData      : registered register-file write port
//   mc_forced                        : FSM is in FORCE_MC
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_reg,
  input  logic [DATA_W-1:0]     mc_data,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     writeData,
  output logic                  mc_forced
);

  arb_state_e            state_q, state_d;
  logic                  wb_xfer, mc_xfer;
  logic                  starve_inc, starve_clr, starve_hit;
  logic                  regWrite_q, regWrite_d;
  logic [REG_ADDR_W-1:0] writeReg_q, writeReg_d;
  logic [DATA_W-1:0]     writeData_q, writeData_d;

  // Readies are gated by rst_n so nothing handshakes while reset is held.
  assign wb_ready = rst_n && wb_valid && (state_q == WB_PRI);
  assign mc_ready = rst_n && mc_valid && ((state_q == FORCE_MC) || !wb_valid);

  assign wb_xfer = wb_valid && wb_ready;
  assign mc_xfer = mc_valid && mc_ready;

  assign starve_inc = mc_valid && !mc_ready;
  assign starve_clr = mc_xfer || !mc_valid;

  starve_counter #(
    .CNT_W (STARVE_CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (starve_inc),
    .clr_i (starve_clr),
    .hit_o (starve_hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_PRI:   if (starve_hit) state_d = FORCE_MC;
      FORCE_MC: if (starve_clr) state_d = WB_PRI;
      default:  state_d = WB_PRI;
    endcase
  end

  // Register 0 is hardwired: the address/data still update for visibility
  // but the write enable is suppressed.
  always_comb begin
    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    if (wb_xfer) begin
      regWrite_d  = (wb_reg != '0);
      writeReg_d  = wb_reg;
      writeData_d = wb_data;
    end else if (mc_xfer) begin
      regWrite_d  = (mc_reg != '0);
      writeReg_d  = mc_reg;
      writeData_d = mc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WB_PRI;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      state_q     <= state_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
    end
  end

  assign regWrite  = regWrite_q;
  assign writeReg  = writeReg_q;
  assign writeData = writeData_q;
  assign mc_forced = (state_q == FORCE_MC);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a directed vector table,
// hand-written reset/withdraw sequences and randomized traffic compared
// against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

  localparam int unsigned LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0, mc_valid = 1'b0;
  logic [4:0]  wb_reg = '0, mc_reg = '0;
  logic [31:0] wb_data = '0, mc_data = '0;
  logic        wb_ready, mc_ready, regWrite, mc_forced;
  logic [4:0]  writeReg;
  logic [31:0] writeData;

  int n_vec = 0;
  int n_err = 0;

  regfile_write_arbiter #(
    .DATA_W       (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .mc_valid  (mc_valid),
    .mc_ready  (mc_ready),
    .mc_reg    (mc_reg),
    .mc_data   (mc_data),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .mc_forced (mc_forced)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Holds reset for two edges, checks the reset state, releases on a
  // negedge and returns one time unit after the following posedge.
  task automatic reset_dut();
    rst_n = 1'b0;
    wb_valid = 1'b0;
    mc_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_writeReg", 32'(writeReg), 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_forced", 32'(mc_forced), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        e_wrdy;
    logic        e_mrdy;
    logic        e_forced;
    logic        e_rw;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[10];

  // random-phase model state
  int          stall;
  int          dut_age;
  logic        m_f, m_wr, m_mr, wb_x, mc_x;
  logic        e_rw;
  logic [4:0]  e_reg;
  logic [31:0] e_data;

  initial begin
    //              wv wr    wd            mv mr    md            wrdy mrdy f  rw reg   data
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF};
    tbl[3] = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd9, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h11};
    tbl[4] = '{1'b1, 5'd2, 32'h22,       1'b1, 5'd9, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22};
    tbl[5] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd9, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33};
    tbl[6] = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd9, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h12345678};
    tbl[7] = '{1'b1, 5'd4, 32'h44,       1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h44};
    tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77,       1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77};
    tbl[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77};

    // ---- directed vector table ----
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      wb_valid = tbl[i].wv; wb_reg = tbl[i].wr; wb_data = tbl[i].wd;
      mc_valid = tbl[i].mv; mc_reg = tbl[i].mr; mc_data = tbl[i].md;
      @(negedge clk);
      chk($sformatf("tbl%0d_wb_ready", i), 32'(wb_ready), 32'(tbl[i].e_wrdy));
      chk($sformatf("tbl%0d_mc_ready", i), 32'(mc_ready), 32'(tbl[i].e_mrdy));
      chk($sformatf("tbl%0d_forced", i), 32'(mc_forced), 32'(tbl[i].e_forced));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_regWrite", i), 32'(regWrite), 32'(tbl[i].e_rw));
      chk($sformatf("tbl%0d_writeReg", i), 32'(writeReg), 32'(tbl[i].e_reg));
      chk($sformatf("tbl%0d_writeData", i), writeData, tbl[i].e_data);
    end

    // ---- mc withdraws while forced ----
    reset_dut();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hA5A5A5A5;
    mc_valid = 1'b1; mc_reg = 5'd12; mc_data = 32'hC0C0C0C0;
    repeat (3) @(posedge clk);
    #1;
    chk("wd_forced", 32'(mc_forced), 32'd1);
    chk("wd_wb_ready", 32'(wb_ready), 32'd0);
    chk("wd_mc_ready", 32'(mc_ready), 32'd1);
    mc_valid = 1'b0;
    @(negedge clk);
    chk("wd_mc_ready_drop", 32'(mc_ready), 32'd0);
    chk("wd_wb_ready_drop", 32'(wb_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("wd_forced_exit", 32'(mc_forced), 32'd0);
    chk("wd_no_write", 32'(regWrite), 32'd0);
    mc_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("wd_cnt_cleared", 32'(mc_forced), 32'd0);
    @(posedge clk);
    #1;
    chk("wd_reforced", 32'(mc_forced), 32'd1);

    // ---- asynchronous reset in the middle of a forced cycle ----
    reset_dut();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h00000333;
    mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 32'h12345678;
    repeat (3) @(posedge clk);
    #2;
    chk("ar_forced_before", 32'(mc_forced), 32'd1);
    chk("ar_write_before", 32'(regWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_regWrite", 32'(regWrite), 32'd0);
    chk("ar_writeReg", 32'(writeReg), 32'd0);
    chk("ar_writeData", writeData, 32'd0);
    chk("ar_forced", 32'(mc_forced), 32'd0);
    chk("ar_wb_ready", 32'(wb_ready), 32'd0);
    chk("ar_mc_ready", 32'(mc_ready), 32'd0);
    wb_valid = 1'b0;
    mc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("ar_no_write_after", 32'(regWrite), 32'd0);
      chk("ar_forced_after", 32'(mc_forced), 32'd0);
    end

    // ---- randomized traffic against the behavioural model ----
    reset_dut();
    stall = 0; dut_age = 0;
    wb_x = 1'b0; mc_x = 1'b0;
    e_rw = 1'b0; e_reg = '0; e_data = '0;
    for (int c = 0; c < 10000; c++) begin
      // requesters keep valid/payload until their transfer completes
      if (!wb_valid || wb_x) begin
        wb_valid = ($urandom % 4) != 0;
        wb_reg   = 5'($urandom);
        wb_data  = $urandom;
      end
      if (!mc_valid || mc_x) begin
        mc_valid = ($urandom % 3) != 0;
        mc_reg   = 5'($urandom);
        mc_data  = $urandom;
      end
      @(negedge clk);
      m_f  = (stall >= int'(LIMIT));
      m_wr = wb_valid && !m_f;
      m_mr = mc_valid && (m_f || !wb_valid);
      chk("rnd_wb_ready", 32'(wb_ready), 32'(m_wr));
      chk("rnd_mc_ready", 32'(mc_ready), 32'(m_mr));
      chk("rnd_forced", 32'(mc_forced), 32'(m_f));
      chk("rnd_both_ready", 32'(wb_ready && mc_ready), 32'd0);
      if (mc_valid) begin
        dut_age++;
        if (mc_ready) begin
          chk("rnd_mc_wait_bound", 32'(dut_age <= int'(LIMIT) + 1), 32'd1);
          dut_age = 0;
        end
      end else begin
        dut_age = 0;
      end
      wb_x = m_wr;
      mc_x = m_mr;
      if (!mc_valid || m_mr) stall = 0;
      else if (stall < 15) stall++;
      if (wb_x) begin
        e_rw = (wb_reg != 5'd0); e_reg = wb_reg; e_data = wb_data;
      end else if (mc_x) begin
        e_rw = (mc_reg != 5'd0); e_reg = mc_reg; e_data = mc_data;
      end else begin
        e_rw = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("rnd_regWrite", 32'(regWrite), 32'(e_rw));
      chk("rnd_writeReg", 32'(writeReg), 32'(e_reg));
      chk("rnd_writeData", writeData, e_data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, write-data width.
REQ-002 Parameter STARVE_LIMIT, default 3, consecutive stalled mc cycles before mc is forced; legal range 1..15.
REQ-003 clk  input  1  sole clock, all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wb_valid  input  1  pipeline writeback request.
REQ-006 wb_ready  output  1  writeback accepted this cycle.
REQ-007 wb_reg  input  5  writeback destination register.
REQ-008 wb_data  input  DATA_W  writeback data.
REQ-009 mc_valid  input  1  multi-cycle unit write request.
REQ-010 mc_ready  output  1  multi-cycle write accepted this cycle.
REQ-011 mc_reg  input  5  multi-cycle destination register.
REQ-012 mc_data  input  DATA_W  multi-cycle data.
REQ-013 regWrite  output  1  register-file write enable, registered.
REQ-014 writeReg  output  5  register-file write address, registered.
REQ-015 writeData  output  DATA_W  register-file write data, registered.
REQ-016 mc_forced  output  1  high while FSM is in FORCE_MC.

Function
REQ-017 Transfer on a port occurs in a cycle where valid and ready are both high at posedge clk.
REQ-018 Ready outputs are combinational from FSM state and valids; ready never depends on the same port's payload.
REQ-019 Requester holds valid and payload stable until transfer; arbiter behaviour is undefined otherwise.
REQ-020 FSM states: WB_PRI (default), FORCE_MC.
REQ-021 WB_PRI: wb_ready = wb_valid; mc_ready = mc_valid and not wb_valid.
REQ-022 FORCE_MC: mc_ready = mc_valid; wb_ready = 0.
REQ-023 Starve counter (4 bits) increments each cycle mc_valid=1 and mc_ready=0; clears on mc transfer or mc_valid=0.
REQ-024 WB_PRI -> FORCE_MC at posedge where counter increments to STARVE_LIMIT.
REQ-025 FORCE_MC -> WB_PRI at posedge of mc transfer, or if mc_valid drops (counter cleared).
REQ-026 At most one transfer per cycle; wb_ready and mc_ready never both high.
REQ-027 Transfer latency: granted payload appears on writeReg/writeData with regWrite=1 in the cycle after transfer (one posedge).
REQ-028 Transfer with destination register 0 completes handshake but drives regWrite=0 next cycle; writeReg/writeData still update.
REQ-029 Cycle with no transfer: regWrite=0 next cycle; writeReg/writeData hold previous values.
REQ-030 No address ordering between ports; same-register collision resolved purely by grant order.
REQ-031 Counter saturates at 15; never wraps.

Reset
REQ-032 rst_n low asynchronously forces: state WB_PRI, counter 0, regWrite 0, writeReg 0, writeData 0, mc_forced 0.
REQ-033 While rst_n low, wb_ready=0 and mc_ready=0 regardless of valids.
REQ-034 Reset mid-FORCE_MC abandons pending mc request; no write issued; first post-reset cycle follows WB_PRI rules.

Structure
REQ-035 Package regfile_arb_pkg holds state enum (WB_PRI, FORCE_MC), REG_ADDR_W=5, default DATA_W, counter width.
REQ-036 Single sub-module starve_counter (increment, clear, saturate, compare-to-limit); all else in top.

Verification
REQ-037 wb only: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF -> wb_ready=1 same cycle; next cycle regWrite=1, writeReg=5, writeData=0xDEADBEEF.
REQ-038 Contention, STARVE_LIMIT=3: wb_valid and mc_valid held high (mc_reg=9, mc_data=0x12345678) -> wb granted 3 cycles, mc_forced=1 in cycle 4, mc transfer cycle 4, regWrite/writeReg=9 cycle 5, then WB_PRI.
REQ-039 Register-0 write: wb_reg=0, wb_data=0xFFFFFFFF -> handshake completes, next cycle regWrite=0.
REQ-040 mc_valid drops in FORCE_MC before grant -> state returns WB_PRI, counter 0, no write.
REQ-041 rst_n asserted mid-cycle during FORCE_MC -> all outputs zero immediately, readies low, no write after release.
REQ-042 Random valid traffic, 10k cycles -> never both readies high; every transfer yields exactly one write-port cycle; mc wait never exceeds STARVE_LIMIT+1 cycles.
